// File: rtl/adc_model_pkg.sv
// rtl/adc_model_pkg.sv - shared constants, state type and LFSR step for the SPI A2D slave model
package adc_model_pkg;

    localparam int FRAME_LEN = 16;
    localparam int ADDR_MSB  = 13;
    localparam int ADDR_LSB  = 11;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shifting Galois form of x^16+x^14+x^13+x^11
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// rtl/spi_edge_sync.sv - 2-flop synchroniser with rise/fall pulses taken from the 2nd/3rd flops
module spi_edge_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [2:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= {3{RST_VAL}};
        end else begin
            ff <= {ff[1:0], d};
        end
    end

    assign rise = ff[1] & ~ff[2];
    assign fall = ~ff[1] & ff[2];

endmodule

// File: rtl/adc_spi_mux_model.sv
// rtl/adc_spi_mux_model.sv - multi-channel SPI A2D slave model, one-frame pipelined, with abort/frame stats
// Optional LSB dither enabled by defining ADC_NOISE_EN.
module adc_spi_mux_model
    import adc_model_pkg::*;
#(
    parameter int NUM_CH     = 8,
    parameter int RES        = 12,
    parameter int NOISE_BITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  SS_n,
    input  logic                  SCLK,
    input  logic                  MOSI,
    output logic                  MISO,
    input  logic [NUM_CH*RES-1:0] ch_data,
    output logic [15:0]           frame_cnt,
    output logic [7:0]            abort_cnt,
    output logic [2:0]            cur_ch
);

    logic ss_rise, ss_fall, sclk_rise, sclk_fall;
    logic [1:0] mosi_ff;

    spi_edge_sync #(.RST_VAL(1'b1)) u_ss_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (SS_n),
        .rise (ss_rise),
        .fall (ss_fall)
    );

    spi_edge_sync #(.RST_VAL(1'b1)) u_sclk_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (SCLK),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    // Two flops keep MOSI aligned with the SCLK rise pulse taken from the 2nd flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_ff <= 2'b00;
        end else begin
            mosi_ff <= {mosi_ff[0], MOSI};
        end
    end

    state_t               state;
    logic [4:0]           bit_cnt;
    logic [15:0]          tx_shft;
    logic [ADDR_MSB:0]    rx_shft;
    logic [RES-1:0]       sel_data;
    logic [RES-1:0]       ret_data;
    logic [15:0]          tx_word;

    always_comb begin
        sel_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (cur_ch == c[2:0]) begin
                sel_data = ch_data[c*RES +: RES];
            end
        end
    end

`ifdef ADC_NOISE_EN
    localparam logic [RES-1:0] NOISE_MASK = RES'((32'd1 << NOISE_BITS) - 32'd1);
    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else if (state == IDLE && ss_fall) begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    assign ret_data = sel_data ^ (lfsr[RES-1:0] & NOISE_MASK);
`else
    assign ret_data = sel_data;
`endif

    assign tx_word = 16'(ret_data);
    assign MISO    = (state == IDLE) ? 1'b1 : tx_shft[15];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            tx_shft   <= '0;
            rx_shft   <= '0;
            frame_cnt <= '0;
            abort_cnt <= '0;
            cur_ch    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ss_fall) begin
                        tx_shft <= tx_word;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_cnt == 5'(FRAME_LEN)) begin
                        cur_ch    <= rx_shft[ADDR_MSB:ADDR_LSB];
                        frame_cnt <= frame_cnt + 16'd1;
                        tx_shft   <= '0;
                        state     <= ss_rise ? IDLE : DONE;
                    end else if (ss_rise) begin
                        if (abort_cnt != 8'hFF) begin
                            abort_cnt <= abort_cnt + 8'd1;
                        end
                        state <= IDLE;
                    end else if (sclk_rise) begin
                        rx_shft <= {rx_shft[ADDR_MSB-1:0], mosi_ff[1]};
                        bit_cnt <= bit_cnt + 5'd1;
                    end else if (sclk_fall && bit_cnt != 5'd0) begin
                        // A fall ahead of the first rise must not drop the MSB
                        tx_shft <= {tx_shft[14:0], 1'b0};
                    end
                end
                DONE: begin
                    if (ss_rise) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_spi_mux_model.sv
// tb/tb_adc_spi_mux_model.sv - self-checking bench for adc_spi_mux_model (8- and 4-channel instances)
module tb_adc_spi_mux_model;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic SS_n = 1'b1;
    logic SCLK = 1'b1;
    logic MOSI = 1'b0;

    always #5 clk = ~clk;

    logic [11:0] ch [8];
    logic [95:0] ch_data8;
    logic [47:0] ch_data4;
    logic        miso8, miso4;
    logic [15:0] fc8, fc4;
    logic [7:0]  ac8, ac4;
    logic [2:0]  cc8, cc4;

    always_comb begin
        for (int c = 0; c < 8; c++) ch_data8[c*12 +: 12] = ch[c];
        for (int c = 0; c < 4; c++) ch_data4[c*12 +: 12] = ch[c];
    end

    adc_spi_mux_model #(.NUM_CH(8), .RES(12), .NOISE_BITS(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(miso8),
        .ch_data(ch_data8), .frame_cnt(fc8), .abort_cnt(ac8), .cur_ch(cc8)
    );

    adc_spi_mux_model #(.NUM_CH(4), .RES(12), .NOISE_BITS(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(miso4),
        .ch_data(ch_data4), .frame_cnt(fc4), .abort_cnt(ac4), .cur_ch(cc4)
    );

`ifdef ADC_NOISE_EN
    localparam logic [15:0] NMASK = 16'h0003;
`else
    localparam logic [15:0] NMASK = 16'h0000;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: last completed address, frame and abort counts
    int m_ch = 0;
    int m_frames = 0;
    int m_aborts = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Received word holds nb bits right-justified; dithered LSBs are not compared
    task automatic check_word(input string name, input logic [15:0] act, input logic [15:0] exp,
                              input int nb);
        logic [15:0] m;
        int sh;
        if (nb == 0) return;
        sh = 16 - nb;
        m = NMASK >> sh;
        check(name, 32'(act & ~m), 32'((exp >> sh) & ~m));
    endtask

    function automatic logic [15:0] exp_word(input int nch);
        return (m_ch < nch) ? {4'h0, ch[m_ch]} : 16'h0000;
    endfunction

    task automatic frame(input logic [2:0] addr, input int nb, input int chg_bit,
                         input logic [11:0] chg_val, output logic [15:0] r8, output logic [15:0] r4);
        logic [15:0] cmd;
        cmd = {2'b00, addr, 11'b0};
        r8 = '0;
        r4 = '0;
        @(negedge clk) SS_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            if (i == chg_bit) ch[1] = chg_val;
            SCLK = 1'b0;
            MOSI = cmd[15-i];
            repeat (3) @(negedge clk);
            SCLK = 1'b1;
            repeat (3) @(negedge clk);
            r8 = {r8[14:0], miso8};
            r4 = {r4[14:0], miso4};
        end
        repeat (3) @(negedge clk);
        SS_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_fc8"}, 32'(fc8), 32'(m_frames));
        check({tag, "_fc4"}, 32'(fc4), 32'(m_frames));
        check({tag, "_ac8"}, 32'(ac8), 32'(m_aborts));
        check({tag, "_ac4"}, 32'(ac4), 32'(m_aborts));
        check({tag, "_cc8"}, 32'(cc8), 32'(m_ch));
        check({tag, "_cc4"}, 32'(cc4), 32'(m_ch));
    endtask

    task automatic run_and_check(input logic [2:0] addr, input int nb, input int chg_bit,
                                 input logic [11:0] chg_val, input string tag,
                                 output logic [15:0] r8);
        logic [15:0] e8, e4, r4;
        e8 = exp_word(8);
        e4 = exp_word(4);
        frame(addr, nb, chg_bit, chg_val, r8, r4);
        check_word({tag, "_w8"}, r8, e8, nb);
        check_word({tag, "_w4"}, r4, e4, nb);
        if (nb == 16) begin
            m_ch = int'(addr);
            m_frames = (m_frames + 1) & 16'hFFFF;
        end else if (m_aborts < 255) begin
            m_aborts++;
        end
        check_state(tag);
        check({tag, "_idle_miso"}, 32'(miso8), 32'd1);
    endtask

    typedef struct {
        logic [2:0]  addr;
        int          nb;
        logic [15:0] e8;
        logic [15:0] e4;
        logic [15:0] fc;
        logic [7:0]  ac;
        logic [2:0]  cc;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] r8, r4;
        logic [3:0]  seen;
        int          distinct;

        ch[0] = 12'h0A0; ch[1] = 12'h100; ch[2] = 12'h555; ch[3] = 12'h333;
        ch[4] = 12'h444; ch[5] = 12'hABC; ch[6] = 12'h666; ch[7] = 12'h777;

        vecs[0] = '{3'd2, 16, 16'h00A0, 16'h00A0, 16'd1, 8'd0, 3'd2};
        vecs[1] = '{3'd0, 16, 16'h0555, 16'h0555, 16'd2, 8'd0, 3'd0};
        vecs[2] = '{3'd5, 16, 16'h00A0, 16'h00A0, 16'd3, 8'd0, 3'd5};
        vecs[3] = '{3'd1, 16, 16'h0ABC, 16'h0000, 16'd4, 8'd0, 3'd1};
        vecs[4] = '{3'd3,  9, 16'h0100, 16'h0100, 16'd4, 8'd1, 3'd1};
        vecs[5] = '{3'd7, 16, 16'h0100, 16'h0100, 16'd5, 8'd1, 3'd7};
        vecs[6] = '{3'd0, 16, 16'h0777, 16'h0000, 16'd6, 8'd1, 3'd0};

        repeat (4) @(negedge clk);
        check("rst_miso8", 32'(miso8), 32'd1);
        check("rst_miso4", 32'(miso4), 32'd1);
        check_state("rst");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            frame(vecs[i].addr, vecs[i].nb, -1, 12'h0, r8, r4);
            check_word($sformatf("vec%0d_w8", i), r8, vecs[i].e8, vecs[i].nb);
            check_word($sformatf("vec%0d_w4", i), r4, vecs[i].e4, vecs[i].nb);
            check($sformatf("vec%0d_fc", i), 32'(fc8), 32'(vecs[i].fc));
            check($sformatf("vec%0d_ac", i), 32'(ac8), 32'(vecs[i].ac));
            check($sformatf("vec%0d_cc8", i), 32'(cc8), 32'(vecs[i].cc));
            check($sformatf("vec%0d_cc4", i), 32'(cc4), 32'(vecs[i].cc));
        end
        m_ch = 0;
        m_frames = 6;
        m_aborts = 1;

        // Data changed mid-frame must not disturb the word in flight
        run_and_check(3'd1, 16, -1, 12'h0, "chg_prime", r8);
        run_and_check(3'd1, 16, 6, 12'hFFF, "chg_old", r8);
        check_word("chg_old_const", r8, 16'h0100, 16);
        run_and_check(3'd0, 16, -1, 12'h0, "chg_new", r8);
        check_word("chg_new_const", r8, 16'h0FFF, 16);
        ch[1] = 12'h100;

        // Reset in the middle of a frame
        run_and_check(3'd3, 16, -1, 12'h0, "prerst", r8);
        @(negedge clk) SS_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            SCLK = 1'b0;
            MOSI = 1'b1;
            repeat (3) @(negedge clk);
            SCLK = 1'b1;
            repeat (3) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        m_ch = 0;
        m_frames = 0;
        m_aborts = 0;
        check("midrst_miso8", 32'(miso8), 32'd1);
        check_state("midrst");
        @(negedge clk);
        SS_n = 1'b1;
        SCLK = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        run_and_check(3'd2, 16, -1, 12'h0, "postrst", r8);
        check_word("postrst_const", r8, 16'h00A0, 16);

        // Abort counter saturates
        for (int i = 0; i < 260; i++) begin
            run_and_check(3'd4, 0, -1, 12'h0, "sat", r8);
        end
        check("sat_final", 32'(ac8), 32'hFF);

        // Randomised frames and channel data against the model
        for (int k = 0; k < 120; k++) begin
            for (int c = 0; c < 8; c++) begin
                if ($urandom_range(0, 2) == 0) ch[c] = 12'($urandom);
            end
            run_and_check(3'($urandom_range(0, 7)),
                          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 16,
                          -1, 12'h0, "rnd", r8);
        end

        // Dither on a fixed mid-scale input
        ch[0] = 12'h800;
        run_and_check(3'd0, 16, -1, 12'h0, "noise_prime", r8);
        seen = '0;
        for (int k = 0; k < 200; k++) begin
            run_and_check(3'd0, 16, -1, 12'h0, "noise", r8);
`ifdef ADC_NOISE_EN
            check("noise_range", 32'(r8 >= 16'h0800 && r8 <= 16'h0803), 32'd1);
            seen[r8[1:0]] = 1'b1;
`else
            check("noise_exact", 32'(r8), 32'h0800);
`endif
        end
`ifdef ADC_NOISE_EN
        distinct = 0;
        for (int i = 0; i < 4; i++) distinct += int'(seen[i]);
        check("noise_distinct", 32'(distinct >= 2), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
